// File: rtl/present_dec_key_sched.sv
// PRESENT decryption round-key generator: runs the forward key schedule to K32,
// then walks the inverse schedule down to K1, one key per valid/ready transfer.
module present_dec_key_sched #(
  parameter int KEY_SIZE = 80
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [KEY_SIZE-1:0] key_in,
  input  logic                rk_ready,
  output logic                rk_valid,
  output logic [63:0]         rk_out,
  output logic [5:0]          rk_idx,
  output logic                rk_last,
  output logic                busy,
  output logic                done
);

  // Handshake: a key moves on every rising edge where rk_valid && rk_ready;
  // rk_valid, rk_out and rk_idx never depend on rk_ready within a cycle.

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRECOMP = 2'd1,
    ST_RUN     = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };
  localparam logic [3:0] SINV [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  state_e              state_q, state_d;
  logic [KEY_SIZE-1:0] key_q, key_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [KEY_SIZE-1:0] f_key, finv_key;

  // One forward step F(key_q, cnt_q) and one inverse step Finv(key_q, cnt_q).
  if (KEY_SIZE == 80) begin : g_k80
    logic [79:0] rot, x, y;
    always_comb begin
      rot      = {key_q[18:0], key_q[79:19]};
      f_key    = {SBOX[rot[79:76]], rot[75:20], rot[19:15] ^ cnt_q, rot[14:0]};
      x        = key_q;
      x[19:15] = key_q[19:15] ^ cnt_q;
      y        = {SINV[x[79:76]], x[75:0]};
      finv_key = {y[60:0], y[79:61]};
    end
  end else if (KEY_SIZE == 128) begin : g_k128
    logic [127:0] rot, x, y;
    always_comb begin
      rot      = {key_q[66:0], key_q[127:67]};
      f_key    = {SBOX[rot[127:124]], SBOX[rot[123:120]], rot[119:67],
                  rot[66:62] ^ cnt_q, rot[61:0]};
      x        = key_q;
      x[66:62] = key_q[66:62] ^ cnt_q;
      y        = {SINV[x[127:124]], SINV[x[123:120]], x[119:0]};
      finv_key = {y[60:0], y[127:61]};
    end
  end else begin : g_bad_key_size
    $error("present_dec_key_sched: KEY_SIZE must be 80 or 128");
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            key_d   = key_in;
            cnt_d   = 5'd1;
            state_d = ST_PRECOMP;
          end
        end
        ST_PRECOMP: begin
          key_d = f_key;
          if (cnt_q == 5'd31) state_d = ST_RUN;
          else                cnt_d   = cnt_q + 5'd1;
        end
        ST_RUN: begin
          // cnt_q == 0 means K1 is on the bus (index = cnt + 1).
          if (rk_ready) begin
            if (cnt_q == 5'd0) begin
              state_d = ST_DONE;
            end else begin
              key_d = finv_key;
              cnt_d = cnt_q - 5'd1;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign rk_valid = (state_q == ST_RUN);
  assign rk_out   = key_q[KEY_SIZE-1 -: 64];
  assign rk_idx   = rk_valid ? ({1'b0, cnt_q} + 6'd1) : 6'd0;
  assign rk_last  = rk_valid && (cnt_q == 5'd0);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_present_dec_key_sched.sv
// Bench for present_dec_key_sched: 80- and 128-bit instances run in lockstep and
// are checked against a forward key-schedule model evaluated with shifts and masks.
module tb_present_dec_key_sched;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start, abort, rk_ready;
  logic [79:0]  key80;
  logic [127:0] key128;

  logic        v80, l80, b80, d80, v128, l128, b128, d128;
  logic [63:0] o80, o128;
  logic [5:0]  i80, i128;

  int tests = 0;
  int fails = 0;

  logic [63:0] exp80_q[$];
  logic [63:0] exp128_q[$];

  always #5 clk = ~clk;

  present_dec_key_sched #(.KEY_SIZE(80)) u_dut80 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .key_in(key80), .rk_ready(rk_ready), .rk_valid(v80), .rk_out(o80),
    .rk_idx(i80), .rk_last(l80), .busy(b80), .done(d80)
  );

  present_dec_key_sched #(.KEY_SIZE(128)) u_dut128 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .key_in(key128), .rk_ready(rk_ready), .rk_valid(v128), .rk_out(o128),
    .rk_idx(i128), .rk_last(l128), .busy(b128), .done(d128)
  );

  typedef struct {
    logic [79:0]  k80;
    logic [127:0] k128;
    int           mode;       // 0 always ready, 1 random ready, 2 ten-cycle stall
    int           spam;       // pulse start during PRECOMP and RUN
    int           abort_pre;  // abort when PRECOMP cnt equals this (0 = never)
    int           abort_idx;  // abort when this index is presented (0 = never)
    int           reset_idx;  // drop reset_n when this index is presented
    int           exp_xfers;
    logic         exp_done;
  } vec_t;

  int s_box[16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Encryption-side key update for round counter i on an n-bit key.
  function automatic logic [127:0] f_step(input logic [127:0] k, input int n, input int i);
    logic [127:0] mask;
    int nib;
    mask = (n == 128) ? '1 : ((128'(1) << n) - 128'(1));
    k    = ((k << 61) | (k >> (n - 61))) & mask;
    nib  = int'((k >> (n - 4)) & 128'hF);
    k    = (k & ~(128'hF << (n - 4))) | (128'(s_box[nib]) << (n - 4));
    if (n == 128) begin
      nib = int'((k >> (n - 8)) & 128'hF);
      k   = (k & ~(128'hF << (n - 8))) | (128'(s_box[nib]) << (n - 8));
    end
    k = k ^ (128'(i) << ((n == 80) ? 15 : 62));
    return k;
  endfunction

  task automatic build_exp(input logic [79:0] k80, input logic [127:0] k128);
    logic [127:0] fw80 [1:32];
    logic [127:0] fw128 [1:32];
    exp80_q.delete();
    exp128_q.delete();
    fw80[1]  = {48'b0, k80};
    fw128[1] = k128;
    for (int i = 1; i <= 31; i++) begin
      fw80[i+1]  = f_step(fw80[i], 80, i);
      fw128[i+1] = f_step(fw128[i], 128, i);
    end
    for (int j = 32; j >= 1; j--) begin
      exp80_q.push_back(64'(fw80[j] >> 16));
      exp128_q.push_back(64'(fw128[j] >> 64));
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_busy80"}, b80, 0);
    chk({name, "_busy128"}, b128, 0);
    chk({name, "_valid80"}, v80, 0);
    chk({name, "_valid128"}, v128, 0);
    chk({name, "_done80"}, d80, 0);
    chk({name, "_done128"}, d128, 0);
  endtask

  task automatic chk_zero(input string name);
    chk_idle(name);
    chk({name, "_out80"}, o80, 0);
    chk({name, "_out128"}, o128, 0);
    chk({name, "_idx80"}, i80, 0);
    chk({name, "_idx128"}, i128, 0);
    chk({name, "_last80"}, l80, 0);
    chk({name, "_last128"}, l128, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int lat, xfers, cyc, exp_idx, stall;
    logic r;
    build_exp(v.k80, v.k128);
    key80    = v.k80;
    key128   = v.k128;
    start    = 1'b1;
    rk_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {b80, b128}, 2'b11);
    lat = 0;
    while (!v80 && lat < 200) begin
      if (v.abort_pre != 0 && lat + 1 == v.abort_pre) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_idle("abort_pre");
        @(negedge clk);
        chk("abort_pre_no_done", {d80, d128}, {v.exp_done, v.exp_done});
        chk("abort_pre_xfers", 0, v.exp_xfers);
        return;
      end
      start = (v.spam != 0 && lat == 15);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("first_valid_latency", lat, 31);
    chk("valid128_with_80", v128, v80);
    if (lat != 31) return;

    exp_idx = 32;
    xfers   = 0;
    cyc     = 0;
    stall   = 0;
    while (exp_idx >= 1 && cyc < 2000) begin
      chk("valid80", v80, 1);
      chk("valid128", v128, 1);
      chk("rk_out80", o80, exp80_q[0]);
      chk("rk_out128", o128, exp128_q[0]);
      chk("rk_idx80", i80, exp_idx);
      chk("rk_idx128", i128, exp_idx);
      chk("rk_last", {l80, l128}, (exp_idx == 1) ? 2'b11 : 2'b00);
      if (v.k80 == 80'h0 && exp_idx == 2) chk("kat_idx2", o80, 64'hC000_0000_0000_0000);
      if (v.k80 == 80'h0 && exp_idx == 1) chk("kat_idx1", o80, 64'h0);
      if (v.reset_idx == exp_idx) begin
        rk_ready = 1'b0;
        reset_n  = 1'b0;
        #1;
        chk_zero("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        chk("reset_xfers", xfers, v.exp_xfers);
        return;
      end
      if (v.abort_idx == exp_idx) begin
        abort    = 1'b1;
        rk_ready = 1'b1;
        @(negedge clk);
        abort    = 1'b0;
        rk_ready = 1'b0;
        chk_idle("abort_run");
        @(negedge clk);
        chk("abort_run_no_done", {d80, d128}, {v.exp_done, v.exp_done});
        chk("abort_run_xfers", xfers, v.exp_xfers);
        return;
      end
      case (v.mode)
        0: r = 1'b1;
        1: r = ($urandom_range(0, 1) == 1);
        default: begin
          if (xfers == 5 && stall < 10) begin
            r = 1'b0;
            stall++;
          end else begin
            r = 1'b1;
          end
        end
      endcase
      rk_ready = r;
      start    = (v.spam != 0 && exp_idx == 20);
      if (r) begin
        void'(exp80_q.pop_front());
        void'(exp128_q.pop_front());
        exp_idx--;
        xfers++;
      end
      @(negedge clk);
      cyc++;
    end
    start    = 1'b0;
    rk_ready = 1'b0;
    if (exp_idx >= 1) begin
      chk("run_timeout_idx", exp_idx, 0);
      return;
    end
    chk("done_pulse", {d80, d128}, {v.exp_done, v.exp_done});
    chk("done_valid_low", {v80, v128}, 2'b00);
    chk("done_busy", {b80, b128}, 2'b11);
    @(negedge clk);
    chk("done_one_cycle", {d80, d128}, 2'b00);
    chk("idle_after_done", {b80, b128}, 2'b00);
    chk("xfer_count", xfers, v.exp_xfers);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  vec_t vecs[$];

  initial begin
    vec_t v;
    reset_n  = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    rk_ready = 1'b0;
    key80    = '0;
    key128   = '0;

    vecs.push_back('{80'h0, 128'h0, 0, 0, 0, 0, 0, 32, 1'b1});
    vecs.push_back('{'1, '1, 0, 0, 0, 0, 0, 32, 1'b1});
    vecs.push_back('{80'h0123_4567_89AB_CDEF_0123, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF,
                     1, 0, 0, 0, 0, 32, 1'b1});
    vecs.push_back('{80'(rnd128()), rnd128(), 2, 0, 0, 0, 0, 32, 1'b1});
    vecs.push_back('{80'(rnd128()), rnd128(), 1, 1, 0, 0, 0, 32, 1'b1});
    vecs.push_back('{80'(rnd128()), rnd128(), 0, 0, 10, 0, 0, 0, 1'b0});
    vecs.push_back('{80'(rnd128()), rnd128(), 0, 0, 0, 0, 0, 32, 1'b1});
    vecs.push_back('{80'(rnd128()), rnd128(), 1, 0, 0, 5, 0, 27, 1'b0});
    vecs.push_back('{80'(rnd128()), rnd128(), 0, 0, 0, 0, 0, 32, 1'b1});
    vecs.push_back('{80'(rnd128()), rnd128(), 1, 0, 0, 0, 17, 15, 1'b0});
    vecs.push_back('{80'(rnd128()), rnd128(), 1, 0, 0, 0, 0, 32, 1'b1});
    for (int i = 0; i < 3; i++)
      vecs.push_back('{80'(rnd128()), rnd128(), 1, 0, 0, 0, 0, 32, 1'b1});

    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);
    chk_zero("after_reset");

    // abort together with start in IDLE must keep the block idle
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk_idle("abort_with_start");

    for (int n = 0; n < vecs.size(); n++) begin
      v = vecs[n];
      run_vec(v);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
